// File: rtl/aes_key_expand.sv
// AES S-box byte substitution (FIPS-197 forward table), purely combinational.
module sbox (
  input  logic [7:0] a,
  output logic [7:0] q
);
  localparam logic [2047:0] SBOX_TBL = {
    128'h637c777bf26b6fc53001672bfed7ab76,
    128'hca82c97dfa5947f0add4a2af9ca472c0,
    128'hb7fd9326363ff7cc34a5e5f171d83115,
    128'h04c723c31896059a071280e2eb27b275,
    128'h09832c1a1b6e5aa0523bd6b329e32f84,
    128'h53d100ed20fcb15b6acbbe394a4c58cf,
    128'hd0efaafb434d338545f9027f503c9fa8,
    128'h51a3408f929d38f5bcb6da2110fff3d2,
    128'hcd0c13ec5f974417c4a77e3d645d1973,
    128'h60814fdc222a908846eeb8145ede0bdb,
    128'he0323a0a4906245cc2d3ac629195e479,
    128'he7c8376d8dd54ea96c56f4ea657aae08,
    128'hba78252e1ca6b4c6e8dd741f4bbd8b8a,
    128'h703eb5664803f60e613557b986c11d9e,
    128'he1f8981169d98e949b1e87e9ce5528df,
    128'h8ca1890dbfe6426841992d0fb054bb16
  };

  logic [10:0] base;

  // Entry 0 sits in the most significant byte of the table.
  assign base = 11'd2047 - {a, 3'b000};
  assign q    = SBOX_TBL[base -: 8];
endmodule

// Iterative AES-128 key schedule: one key in, rk0..rk10 streamed out in order.
// Latency: rk0 the cycle after key acceptance, then one round key per cycle at full rate.
// Backpressure: rk/rk_idx hold while rk_valid && !rk_ready; no new key until rk10 is taken.
module aes_key_expand (
  input  logic         clk,
  input  logic         rst_n,
  input  logic [127:0] key,
  input  logic         key_valid,
  output logic         key_ready,
  output logic [127:0] rk,
  output logic [3:0]   rk_idx,
  output logic         rk_valid,
  input  logic         rk_ready,
  output logic         busy
);
  typedef enum logic {IDLE, RUN} state_t;

  state_t       state, state_nx;
  logic [127:0] rk_reg;
  logic [3:0]   idx_q;
  logic [7:0]   rcon;
  logic         load, adv;
  logic [31:0]  rot, sub, t, n0, n1, n2, n3;

  assign rot = {rk_reg[23:0], rk_reg[31:24]};

  for (genvar gi = 0; gi < 4; gi++) begin : g_sbox
    sbox u_sbox (
      .a(rot[8*gi +: 8]),
      .q(sub[8*gi +: 8])
    );
  end

  assign t  = sub ^ {rcon, 24'h0};
  assign n0 = rk_reg[127:96] ^ t;
  assign n1 = rk_reg[95:64]  ^ n0;
  assign n2 = rk_reg[63:32]  ^ n1;
  assign n3 = rk_reg[31:0]   ^ n2;

  always_ff @(posedge clk) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nx;
  end

  // Handshake outputs decode from the state register only.
  always_comb begin
    state_nx  = state;
    key_ready = 1'b0;
    rk_valid  = 1'b0;
    busy      = 1'b0;
    load      = 1'b0;
    adv       = 1'b0;
    case (state)
      IDLE: begin
        key_ready = 1'b1;
        if (key_valid) begin
          load     = 1'b1;
          state_nx = RUN;
        end
      end
      RUN: begin
        rk_valid = 1'b1;
        busy     = 1'b1;
        if (rk_ready) begin
          if (idx_q == 4'd10) state_nx = IDLE;
          else                adv      = 1'b1;
        end
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      rk_reg <= '0;
      idx_q  <= 4'd0;
      rcon   <= 8'h01;
    end else if (load) begin
      rk_reg <= key;
      idx_q  <= 4'd0;
      rcon   <= 8'h01;
    end else if (adv) begin
      rk_reg <= {n0, n1, n2, n3};
      idx_q  <= idx_q + 4'd1;
      rcon   <= {rcon[6:0], 1'b0} ^ (rcon[7] ? 8'h1b : 8'h00);
    end
  end

  assign rk     = rk_reg;
  assign rk_idx = idx_q;
endmodule

// File: tb/tb_aes_key_expand.sv
// Scoreboard bench for aes_key_expand: a reference schedule built from a GF(2^8)
// inverse-based S-box is queued per accepted key and matched against each transfer.
module tb_aes_key_expand;
  logic         clk = 1'b0;
  logic         rst_n;
  logic [127:0] key;
  logic         key_valid;
  logic         key_ready;
  logic [127:0] rk;
  logic [3:0]   rk_idx;
  logic         rk_valid;
  logic         rk_ready;
  logic         busy;

  localparam logic [127:0] K_A1   = 128'h2b7e151628aed2a6abf7158809cf4f3c;
  localparam logic [127:0] K_X    = 128'hdeadbeef0123456789abcdeffedcba98;
  localparam logic [127:0] A1_RK1 = 128'ha0fafe1788542cb123a339392a6c7605;
  localparam logic [127:0] A1_RK10 = 128'hd014f9a8c9ee2589e13f0cc8b6630ca6;
  localparam logic [127:0] Z_RK1  = 128'h62636363626363636263636362636363;
  localparam logic [127:0] Z_RK10 = 128'hb4ef5bcb3e92e21123e951cf6f8f188e;

  aes_key_expand dut (
    .clk(clk), .rst_n(rst_n), .key(key), .key_valid(key_valid), .key_ready(key_ready),
    .rk(rk), .rk_idx(rk_idx), .rk_valid(rk_valid), .rk_ready(rk_ready), .busy(busy)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;
  logic [131:0] sb [$];
  logic [127:0] got_rk [0:10];
  int  last_accept = 0;
  int  accepts     = 0;
  int  rk0_due     = -1;
  bit  spacing_chk = 1'b0;
  bit  full_speed  = 1'b0;
  bit  prev_stall  = 1'b0;
  bit  was_rst     = 1'b0;
  logic [127:0] prev_rk;
  logic [3:0]   prev_idx;

  task automatic chk(input string tag, input logic [131:0] got, input logic [131:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  function automatic logic [7:0] xt(input logic [7:0] r);
    return {r[6:0], 1'b0} ^ (r[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p = 8'h00;
    for (int i = 0; i < 8; i++) begin
      if (b[0]) p = p ^ a;
      a = xt(a);
      b = b >> 1;
    end
    return p;
  endfunction

  // S-box from first principles: multiplicative inverse then affine map.
  function automatic logic [7:0] sbox_ref(input logic [7:0] x);
    logic [7:0] inv = 8'h00;
    for (int i = 1; i < 256; i++)
      if (gmul(x, 8'(i)) == 8'h01) inv = 8'(i);
    return inv ^ {inv[6:0], inv[7]} ^ {inv[5:0], inv[7:6]} ^ {inv[4:0], inv[7:5]}
               ^ {inv[3:0], inv[7:4]} ^ 8'h63;
  endfunction

  function automatic logic [127:0] next_key(input logic [127:0] k, input logic [7:0] rc);
    logic [31:0] w [4];
    logic [31:0] tw;
    for (int i = 0; i < 4; i++) w[i] = k[127-32*i -: 32];
    tw = {sbox_ref(w[3][23:16]) ^ rc, sbox_ref(w[3][15:8]), sbox_ref(w[3][7:0]),
          sbox_ref(w[3][31:24])};
    w[0] = w[0] ^ tw;
    w[1] = w[1] ^ w[0];
    w[2] = w[2] ^ w[1];
    w[3] = w[3] ^ w[2];
    return {w[0], w[1], w[2], w[3]};
  endfunction

  function automatic void push_sched(input logic [127:0] k0);
    logic [127:0] k  = k0;
    logic [7:0]   rc = 8'h01;
    for (int i = 0; i <= 10; i++) begin
      sb.push_back({4'(i), k});
      k  = next_key(k, rc);
      rc = xt(rc);
    end
  endfunction

  // Monitor: samples on the falling edge, i.e. the values the next rising edge will use.
  always @(negedge clk) begin
    cyc++;
    if (rk0_due == cyc) begin
      chk("rk0_lat_vld", 132'(rk_valid), 132'(1));
      chk("rk0_lat_idx", 132'(rk_idx), 132'(0));
    end
    if (was_rst) begin
      chk("rst_rk_valid", 132'(rk_valid), 132'(0));
      chk("rst_busy", 132'(busy), 132'(0));
      chk("rst_key_ready", 132'(key_ready), 132'(1));
      chk("rst_rk_idx", 132'(rk_idx), 132'(0));
    end
    if (prev_stall && rk_valid) begin
      chk("stall_rk", 132'(rk), 132'(prev_rk));
      chk("stall_idx", 132'(rk_idx), 132'(prev_idx));
    end
    if (!rst_n) begin
      sb.delete();
      prev_stall = 1'b0;
      rk0_due    = -1;
      was_rst    = 1'b1;
    end else begin
      was_rst = 1'b0;
      if (rk_valid && rk_ready) begin
        if (sb.size() == 0) begin
          chk("sb_unexpected_rk", {rk_idx, rk}, '0);
        end else begin
          chk("rk", {rk_idx, rk}, sb.pop_front());
          if (rk_idx <= 4'd10) got_rk[rk_idx] = rk;
          if (full_speed && rk_idx == 4'd10)
            chk("sched_len", 132'(cyc - last_accept), 132'(11));
        end
      end
      prev_stall = rk_valid && !rk_ready;
      prev_rk    = rk;
      prev_idx   = rk_idx;
      if (key_valid && key_ready) begin
        if (spacing_chk && accepts > 0)
          chk("key_spacing", 132'(cyc - last_accept), 132'(12));
        accepts++;
        last_accept = cyc;
        rk0_due     = cyc + 1;
        push_sched(key);
      end
    end
  end

  task automatic send_key(input logic [127:0] k);
    key       = k;
    key_valid = 1'b1;
    @(posedge clk); #1;
    key_valid = 1'b0;
  endtask

  task automatic wait_drain();
    bit done = 1'b0;
    for (int n = 0; n < 400 && !done; n++) begin
      @(posedge clk); #1;
      if (sb.size() == 0 && key_ready) done = 1'b1;
    end
    if (!done) chk("drain_timeout", 132'(sb.size()), 132'(0));
  endtask

  initial begin
    bit hit;
    int a0;
    rst_n     = 1'b0;
    key_valid = 1'b0;
    key       = '0;
    rk_ready  = 1'b1;
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;

    // FIPS-197 A.1 key at full rate.
    full_speed = 1'b1;
    send_key(K_A1);
    wait_drain();
    chk("a1_rk0", 132'(got_rk[0]), 132'(K_A1));
    chk("a1_rk1", 132'(got_rk[1]), 132'(A1_RK1));
    chk("a1_rk10", 132'(got_rk[10]), 132'(A1_RK10));

    // All-zero key.
    send_key('0);
    wait_drain();
    chk("zero_rk1", 132'(got_rk[1]), 132'(Z_RK1));
    chk("zero_rk10", 132'(got_rk[10]), 132'(Z_RK10));

    // Random consumer backpressure.
    full_speed = 1'b0;
    for (int i = 0; i <= 10; i++) got_rk[i] = '0;
    send_key(K_A1);
    hit = 1'b0;
    for (int n = 0; n < 600 && !hit; n++) begin
      rk_ready = 1'($urandom_range(0, 1));
      @(posedge clk); #1;
      if (sb.size() == 0 && key_ready) hit = 1'b1;
    end
    rk_ready = 1'b1;
    if (!hit) chk("bp_timeout", 132'(sb.size()), 132'(0));
    chk("bp_rk10", 132'(got_rk[10]), 132'(A1_RK10));

    // Key offered mid-run is ignored; next key taken as soon as key_ready returns.
    send_key(K_A1);
    key       = K_X;
    key_valid = 1'b1;
    for (int n = 0; n < 3; n++) begin
      chk("midrun_key_ready", 132'(key_ready), 132'(0));
      @(posedge clk); #1;
    end
    key_valid = 1'b0;
    hit = 1'b0;
    for (int n = 0; n < 50 && !hit; n++) begin
      @(posedge clk); #1;
      if (key_ready) hit = 1'b1;
    end
    if (!hit) chk("ready_return_timeout", 132'(key_ready), 132'(1));
    send_key('0);
    wait_drain();
    chk("second_key_rk10", 132'(got_rk[10]), 132'(Z_RK10));

    // Synchronous reset while rk_idx == 5, then a fresh schedule.
    full_speed = 1'b1;
    send_key(K_A1);
    hit = 1'b0;
    for (int n = 0; n < 50 && !hit; n++) begin
      if (rk_valid && rk_idx == 4'd5) hit = 1'b1;
      else begin @(posedge clk); #1; end
    end
    if (!hit) chk("idx5_timeout", 132'(rk_idx), 132'(5));
    rst_n = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    for (int i = 0; i <= 10; i++) got_rk[i] = '0;
    send_key(K_A1);
    wait_drain();
    chk("post_rst_rk1", 132'(got_rk[1]), 132'(A1_RK1));
    chk("post_rst_rk10", 132'(got_rk[10]), 132'(A1_RK10));

    // Back-to-back keys with key_valid held high.
    spacing_chk = 1'b1;
    a0          = accepts;
    key         = K_A1;
    key_valid   = 1'b1;
    hit = 1'b0;
    for (int n = 0; n < 100 && !hit; n++) begin
      @(posedge clk); #1;
      if (accepts >= a0 + 3) hit = 1'b1;
    end
    key_valid = 1'b0;
    if (!hit) chk("b2b_timeout", 132'(accepts - a0), 132'(3));
    wait_drain();
    spacing_chk = 1'b0;

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog total=%0d bad=%0d", total, bad);
    $fatal(1, "watchdog expired");
  end
endmodule

// File: doc/aes_key_expand.md
# aes_key_expand

Iterative AES-128 key-schedule engine for the AES-GCM datapath. It accepts a 128-bit cipher key over a valid/ready handshake and streams the 11 round keys (rk0..rk10) in order, one per accepted transfer, to the round pipeline. SubWord is computed by four instances of the team's combinational `sbox` byte-substitution block, fed with the rotated last word of the current round key.

## Interface
- Parameters: none. The block is AES-128 only; all widths are fixed.
- `clk` in 1: single clock. All state updates on the rising edge.
- `rst_n` in 1: synchronous, active-low reset, sampled on the `clk` rising edge.
- `key` in 128: cipher key. Bits [127:96] are word w0 and byte 0 is [127:120], per FIPS-197 ordering.
- `key_valid` in 1: `key` is valid.
- `key_ready` out 1: block can accept a key. Equals (state==IDLE).
- `rk` out 128: current round key, same byte ordering as `key`.
- `rk_idx` out 4: round index of `rk`, 0..10.
- `rk_valid` out 1: `rk`/`rk_idx` are valid.
- `rk_ready` in 1: consumer accepts `rk` this cycle.
- `busy` out 1: equals (state==RUN).

## Operation
- States: IDLE and RUN.
- IDLE:
  - `key_ready`=1, `rk_valid`=0.
  - When `key_valid`&&`key_ready`: `rk_reg`<=`key`, `rk_idx`<=0, `rcon`<=8'h01, go to RUN.
- RUN:
  - `rk_valid`=1. `rk`=`rk_reg`.
  - When `rk_valid`&&`rk_ready` and `rk_idx`==10: go to IDLE. `rk_reg`, `rk_idx` and `rcon` are left unchanged (don't-care).
  - When `rk_valid`&&`rk_ready` and `rk_idx`<10: `rk_reg`<=next, `rk_idx`<=`rk_idx`+1, `rcon`<=xtime(`rcon`).
  - With no handshake, all state holds.
- Next-key function, with w0..w3 the words of `rk_reg` and w3={a0,a1,a2,a3}:
  - rot={a1,a2,a3,a0}.
  - sub = four `sbox` lookups, one per byte of rot.
  - t = sub ^ {`rcon`,24'h0}.
  - n0=w0^t, n1=w1^n0, n2=w2^n1, n3=w3^n2. next={n0,n1,n2,n3}.
- xtime(r) = {r[6:0],1'b0} ^ (r[7] ? 8'h1b : 8'h00), truncated to 8 bits.
  - `rcon` sequence for rk1..rk10: 01,02,04,08,10,20,40,80,1b,36.
- `key_valid` while in RUN is ignored because `key_ready`=0. A new key is never taken mid-schedule.

## Timing
- Reset (`rst_n`=0 at an edge):
  - Next state is IDLE; `rk_valid`=0, `busy`=0, `key_ready`=1.
  - `rk_reg`=0, `rk_idx`=0, `rcon`=8'h01.
  - Applies identically mid-schedule: any in-flight schedule is discarded and no further `rk_valid` is asserted.
- Key accepted at edge N -> `rk_valid`=1 with rk0 (=`key`) during cycle N+1.
- With `rk_ready` held high: rk0..rk10 appear on 11 consecutive cycles.
  - `rk_valid` drops in the cycle after rk10 is accepted, and `key_ready`=1 in that same cycle.
  - Minimum key-to-key spacing is 12 cycles.
- Backpressure: while `rk_valid`&&!`rk_ready`, `rk` and `rk_idx` are stable. `rk_valid` never deasserts before acceptance.
- Next-key logic is single-cycle combinational (4 `sbox` + XOR chain), with no extra pipeline stage.
- `key_ready`, `busy` and `rk_valid` are decoded from the state register only. None depends combinationally on `rk_ready` or `key_valid`.

## Test plan
- FIPS-197 A.1 key 2b7e151628aed2a6abf7158809cf4f3c with `rk_ready`=1:
  - rk0 equals the key.
  - rk1=a0fafe1788542cb123a339392a6c7605.
  - rk10=d014f9a8c9ee2589e13f0cc8b6630ca6.
  - `rk_idx` runs 0..10 on consecutive cycles.
- All-zero key:
  - rk1=62636363626363636263636362636363.
  - rk10=b4ef5bcb3e92e21123e951cf6f8f188e.
- Random `rk_ready` backpressure (~50%) on the A.1 key:
  - The same 11 keys arrive in order.
  - `rk`/`rk_idx` are stable across every stalled cycle.
  - No index is skipped or duplicated.
- Key offered during RUN, then a second key offered the cycle `key_ready` returns:
  - The mid-run key is ignored (`key_ready`=0).
  - The second key is accepted, and its rk0 appears one cycle later.
- `rst_n`=0 for one cycle while `rk_idx`=5:
  - Next cycle: `rk_valid`=0, `busy`=0, `key_ready`=1.
  - A fresh A.1 key afterwards reproduces the full correct sequence (rcon restarts at 01).
- Back-to-back keys with `key_valid` held high: each schedule is exactly 11 transfers, and successive key acceptances are 12 cycles apart.
